combo_lock_ctrl: RTL and testbench
==================================

# combo_lock_ctrl

Sequencing controller for the keypad combination lock. Takes single-cycle key events from the keypad decoding path. Collects a fixed-length code, compares it against the stored combination, and times the unlocked, error and lockout phases. Drives the 4-bit value shown on the seven-segment display controller, plus lock status outputs.

## Interface
- CODE_LEN, 4 — digits per combination (1..8)
- DEFAULT_CODE, 16'h1234 — reset combination, CODE_LEN×4 bits, first digit in the MS nibble
- MAX_FAILS, 3 — consecutive failed attempts that trigger lockout (1..15)
- UNLOCK_CYCLES, 32'd300_000_000 — clk cycles spent unlocked
- ERROR_CYCLES, 32'd100_000_000 — clk cycles the error indication is shown
- LOCKOUT_CYCLES, 32'd1_000_000_000 — clk cycles of lockout
- clk  in  1  system clock, 100 MHz onboard
- reset  in  1  synchronous, active-high; one clock; all state returns to reset values
- key_strobe  in  1  one-cycle pulse, one per key press
- key_code  in  4  key value, sampled when key_strobe=1; 0x0–0xD digits, 0xE ENTER, 0xF CLEAR
- disp_val  out  4  value for the seven-segment controller
- unlocked  out  1  high while in UNLOCKED (or PROG)
- err  out  1  high while in ERROR
- locked_out  out  1  high while in LOCKOUT
- fail_cnt  out  4  current consecutive failure count

## Operation
- States: IDLE, ENTRY, CHECK, UNLOCKED, ERROR, LOCKOUT; PROG exists only with COMBO_PROG_EN.
- IDLE:
  - digit → entry = {entry, digit}, digit count = 1, go to ENTRY
  - ENTER → CHECK with an empty entry, which counts as a failure
  - CLEAR → ignored
- ENTRY:
  - digit shifts into entry and the count increments while count < CODE_LEN
  - further digits set an overflow flag; entry and count are unchanged
  - CLEAR zeroes entry, count and overflow, then goes to IDLE
  - ENTER → CHECK
- CHECK lasts one cycle:
  - match = (count == CODE_LEN) && !overflow && (entry == stored code)
  - match → UNLOCKED, fail_cnt = 0
  - otherwise fail_cnt++; go to LOCKOUT if the new fail_cnt ≥ MAX_FAILS, else ERROR
  - entry, count and overflow clear on leaving CHECK
- UNLOCKED:
  - leaves for IDLE after UNLOCK_CYCLES
  - CLEAR relocks immediately, going to IDLE
  - digits are ignored
- ERROR: key events ignored; goes to IDLE after ERROR_CYCLES.
- LOCKOUT: key events ignored; goes to IDLE after LOCKOUT_CYCLES with fail_cnt = 0.
- disp_val by state:
  - IDLE: 0x0
  - ENTRY: last accepted digit
  - CHECK: holds its previous value
  - UNLOCKED: 0xA
  - PROG: last programmed digit, or 0xB if none yet
  - ERROR: 0xE
  - LOCKOUT: 0xF
- fail_cnt saturates at 15.
- Reset values: state IDLE, disp_val 0x0, unlocked 0, err 0, locked_out 0, fail_cnt 0, entry 0, stored code = DEFAULT_CODE.

## Timing
- All outputs are registered.
- A key_strobe at edge n takes effect in state and outputs at edge n+1.
- ENTER at n → CHECK at n+1 → UNLOCKED/ERROR/LOCKOUT with its status output high at n+2.
- Timed states hold their status output for exactly the configured cycle count, then are in IDLE on the next edge.
- A key_strobe arriving in CHECK is dropped.
- A key_strobe in the last cycle of a timed state is dropped.
- reset overrides any simultaneous key_strobe.
- reset mid-entry or mid-lockout abandons the operation; values are as listed under Operation.

## Configuration
- COMBO_PROG_EN defined:
  - ENTER in UNLOCKED → PROG, and the timer is frozen
  - in PROG, digits collect as in ENTRY
  - ENTER with exactly CODE_LEN digits and no overflow writes the stored code, then → IDLE
  - any other ENTER, or CLEAR, discards the input and → UNLOCKED with the timer restarted
- COMBO_PROG_EN undefined:
  - PROG state and the code register are absent; stored code is the constant DEFAULT_CODE
  - ENTER in UNLOCKED is ignored

## Structure
- Package combo_lock_pkg holds:
  - the state encoding
  - KEY_ENTER = 4'hE and KEY_CLEAR = 4'hF
  - display codes DISP_OPEN = 4'hA, DISP_PROG = 4'hB, DISP_ERR = 4'hE, DISP_LOCK = 4'hF
- Sub-module hold_timer:
  - 32-bit down-counter with load value, load, freeze and done
  - done pulses in the last cycle of the interval
  - one instance shared by UNLOCKED, ERROR and LOCKOUT

## Test plan
Bench parameters: CODE_LEN=4, DEFAULT_CODE=16'h1234, MAX_FAILS=3, UNLOCK/ERROR/LOCKOUT = 20/10/40.
- Keys 1,2,3,4,ENTER → unlocked=1 two edges after ENTER for exactly 20 cycles; disp_val 0xA, then IDLE with 0x0.
- Keys 1,2,3,5,ENTER three times → err high 10 cycles twice, fail_cnt 1 then 2; third attempt gives locked_out=1 for 40 cycles, keys ignored, then fail_cnt=0.
- Keys 1,2,3,4,5,ENTER → overflow causes failure, err=1; keys 1,2,ENTER → failure.
- Keys 1,2,CLEAR,1,2,3,4,ENTER → unlocked; CLEAR during UNLOCKED → unlocked=0 on the next edge.
- With COMBO_PROG_EN: unlock, ENTER, 9,8,7,6,ENTER → IDLE; 1,2,3,4 now fails and 9,8,7,6 unlocks; reset restores 16'h1234.
- reset asserted during lockout and mid-entry → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the keypad combination lock controller.
// COMBO_PROG_EN adds the code-programming state to the encoding.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StUnlocked,
    StError,
    StLockout
`ifdef COMBO_PROG_EN
    ,
    StProg
`endif
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  localparam logic [3:0] DISP_OPEN = 4'hA;
  localparam logic [3:0] DISP_PROG = 4'hB;
  localparam logic [3:0] DISP_ERR  = 4'hE;
  localparam logic [3:0] DISP_LOCK = 4'hF;

  // Failure counter increment that sticks at 15.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// 32-bit interval timer shared by the timed lock states.
// load_i starts an interval of load_val_i cycles (load_val_i >= 1); done_o is high
// in the last cycle of that interval. freeze_i holds the count and masks done_o.
module hold_timer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] load_val_i,
  input  logic        load_i,
  input  logic        freeze_i,
  output logic        done_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        active_q, active_d;

  // Count down once per cycle while running; stop after the final cycle.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = load_val_i - 32'd1;
      active_d = 1'b1;
    end else if (active_q && !freeze_i) begin
      if (cnt_q == 32'd0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  assign done_o = active_q && !freeze_i && (cnt_q == 32'd0);

  // Timer state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= 32'd0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Keypad combination lock sequencer: collects digits, checks them against the
// stored code and times the unlocked / error / lockout phases.
// Define COMBO_PROG_EN to allow reprogramming the code from the unlocked state.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned             CODE_LEN       = 4,
  parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int unsigned             MAX_FAILS      = 3,
  parameter logic [31:0]             UNLOCK_CYCLES  = 32'd300_000_000,
  parameter logic [31:0]             ERROR_CYCLES   = 32'd100_000_000,
  parameter logic [31:0]             LOCKOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       key_strobe_i,
  input  logic [3:0] key_code_i,
  output logic [3:0] disp_val_o,
  output logic       unlocked_o,
  output logic       err_o,
  output logic       locked_out_o,
  output logic [3:0] fail_cnt_o
);

  localparam int unsigned CodeW    = CODE_LEN * 4;
  localparam logic [3:0]  CodeLenC = 4'(CODE_LEN);
  localparam logic [3:0]  MaxFailC = 4'(MAX_FAILS);

  state_e             state_q, state_d;
  logic [CodeW-1:0]   entry_q, entry_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         disp_q, disp_d;
  logic [3:0]         fail_q, fail_d;
  logic               unlocked_q, unlocked_d;
  logic               err_q, err_d;
  logic               lockout_q, lockout_d;
  logic [CodeW-1:0]   stored_code;

  logic               key_digit, key_enter, key_clear;
  logic               collect;
  logic               match;
  logic [3:0]         fail_inc;
  logic               tmr_load, tmr_freeze, tmr_done;
  logic [31:0]        tmr_val;

`ifdef COMBO_PROG_EN
  logic [CodeW-1:0]   code_q, code_d;
  assign stored_code = code_q;
`else
  assign stored_code = DEFAULT_CODE;
`endif

  assign key_digit = key_strobe_i && (key_code_i < KEY_ENTER);
  assign key_enter = key_strobe_i && (key_code_i == KEY_ENTER);
  assign key_clear = key_strobe_i && (key_code_i == KEY_CLEAR);
  assign match     = (cnt_q == CodeLenC) && !ovf_q && (entry_q == stored_code);
  assign fail_inc  = sat_inc(fail_q);

  hold_timer u_hold_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_val_i (tmr_val),
    .load_i     (tmr_load),
    .freeze_i   (tmr_freeze),
    .done_o     (tmr_done)
  );

  // Next-state, entry buffer, timer control and registered-output values.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    fail_d     = fail_q;
    collect    = 1'b0;
    tmr_load   = 1'b0;
    tmr_freeze = 1'b0;
    tmr_val    = UNLOCK_CYCLES;
`ifdef COMBO_PROG_EN
    code_d     = code_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (key_digit) begin
          entry_d = CodeW'({entry_q, key_code_i});
          cnt_d   = 4'd1;
          disp_d  = key_code_i;
          state_d = StEntry;
        end else if (key_enter) begin
          state_d = StCheck;
        end
      end
      StEntry: begin
        if (key_digit) begin
          collect = 1'b1;
        end else if (key_clear) begin
          entry_d = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else if (key_enter) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        entry_d  = '0;
        cnt_d    = 4'd0;
        ovf_d    = 1'b0;
        tmr_load = 1'b1;
        if (match) begin
          fail_d  = 4'd0;
          tmr_val = UNLOCK_CYCLES;
          state_d = StUnlocked;
        end else begin
          fail_d = fail_inc;
          if (fail_inc >= MaxFailC) begin
            tmr_val = LOCKOUT_CYCLES;
            state_d = StLockout;
          end else begin
            tmr_val = ERROR_CYCLES;
            state_d = StError;
          end
        end
      end
      StUnlocked: begin
        // Expiry wins over any key arriving in the final cycle.
        if (tmr_done || key_clear) begin
          state_d = StIdle;
`ifdef COMBO_PROG_EN
        end else if (key_enter) begin
          disp_d  = DISP_PROG;
          state_d = StProg;
`endif
        end
      end
      StError: begin
        if (tmr_done) begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (tmr_done) begin
          fail_d  = 4'd0;
          state_d = StIdle;
        end
      end
`ifdef COMBO_PROG_EN
      StProg: begin
        tmr_freeze = 1'b1;
        if (key_digit) begin
          collect = 1'b1;
        end else if (key_enter || key_clear) begin
          if (key_enter && (cnt_q == CodeLenC) && !ovf_q) begin
            code_d  = entry_q;
            state_d = StIdle;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = UNLOCK_CYCLES;
            state_d  = StUnlocked;
          end
          entry_d = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Digit collection shared by entry and programming.
    if (collect) begin
      if (cnt_q < CodeLenC) begin
        entry_d = CodeW'({entry_q, key_code_i});
        cnt_d   = cnt_q + 4'd1;
        disp_d  = key_code_i;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Fixed display codes follow the state being entered.
    case (state_d)
      StIdle:     disp_d = 4'h0;
      StUnlocked: disp_d = DISP_OPEN;
      StError:    disp_d = DISP_ERR;
      StLockout:  disp_d = DISP_LOCK;
      default:    ;
    endcase

`ifdef COMBO_PROG_EN
    unlocked_d = (state_d == StUnlocked) || (state_d == StProg);
`else
    unlocked_d = (state_d == StUnlocked);
`endif
    err_d     = (state_d == StError);
    lockout_d = (state_d == StLockout);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      cnt_q      <= 4'd0;
      ovf_q      <= 1'b0;
      disp_q     <= 4'h0;
      fail_q     <= 4'd0;
      unlocked_q <= 1'b0;
      err_q      <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      err_q      <= err_d;
      lockout_q  <= lockout_d;
    end
  end

`ifdef COMBO_PROG_EN
  // Programmable combination register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      code_q <= DEFAULT_CODE;
    end else begin
      code_q <= code_d;
    end
  end
`endif

  assign disp_val_o   = disp_q;
  assign unlocked_o   = unlocked_q;
  assign err_o        = err_q;
  assign locked_out_o = lockout_q;
  assign fail_cnt_o   = fail_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with short timed phases (20/10/40 cycles).
module tb_combo_lock_ctrl;

  localparam logic [3:0] ENT = 4'hE;
  localparam logic [3:0] CLR = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_strobe = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] disp_val;
  logic       unlocked, err, locked_out;
  logic [3:0] fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  combo_lock_ctrl #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (32'd20),
    .ERROR_CYCLES   (32'd10),
    .LOCKOUT_CYCLES (32'd40)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .key_strobe_i (key_strobe),
    .key_code_i   (key_code),
    .disp_val_o   (disp_val),
    .unlocked_o   (unlocked),
    .err_o        (err),
    .locked_out_o (locked_out),
    .fail_cnt_o   (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] d, input logic u,
                            input logic e, input logic l, input logic [3:0] f);
    check_eq({tag, ".disp"}, 32'(disp_val), 32'(d));
    check_eq({tag, ".unlocked"}, 32'(unlocked), 32'(u));
    check_eq({tag, ".err"}, 32'(err), 32'(e));
    check_eq({tag, ".locked_out"}, 32'(locked_out), 32'(l));
    check_eq({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(f));
  endtask

  // All tasks start and end on a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_code   = k;
    key_strobe = 1'b1;
    @(negedge clk);
    key_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key_strobe = 1'b0;
  endtask

  function automatic logic status(input int which);
    case (which)
      0:       return unlocked;
      1:       return err;
      default: return locked_out;
    endcase
  endfunction

  // Count cycles the selected status stays high, injecting keys that must be
  // ignored, including one in the final cycle of the interval.
  task automatic run_timed(input int which, input int len, output int cnt);
    cnt = 0;
    while (status(which) && cnt < 200) begin
      key_strobe = 1'b0;
      if (cnt >= 2 && cnt < 6) begin
        key_strobe = 1'b1;
        key_code   = 4'(cnt - 1);
      end else if (cnt == 6) begin
        key_strobe = 1'b1;
        key_code   = (which == 0) ? 4'h9 : ENT;
      end else if (cnt == len - 1) begin
        key_strobe = 1'b1;
        key_code   = 4'h7;
      end
      cnt++;
      @(negedge clk);
    end
    key_strobe = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(ENT);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Correct code unlocks for exactly 20 cycles.
    press(4'h1);
    check_eq("t1.disp_first", 32'(disp_val), 32'h1);
    press(4'h2); press(4'h3); press(4'h4);
    check_eq("t1.disp_last", 32'(disp_val), 32'h4);
    press(ENT);
    check_outs("t1.check", 4'h4, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    check_outs("t1.open", 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    run_timed(0, 20, n);
    check_eq("t1.unlock_len", 32'(n), 32'd20);
    check_outs("t1.idle", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Three wrong codes: two errors then lockout.
    for (int a = 1; a <= 2; a++) begin
      enter_code(16'h1235);
      step();
      check_outs($sformatf("t2.err%0d", a), 4'hE, 1'b0, 1'b1, 1'b0, 4'(a));
      run_timed(1, 10, n);
      check_eq($sformatf("t2.err_len%0d", a), 32'(n), 32'd10);
      check_eq($sformatf("t2.idle_disp%0d", a), 32'(disp_val), 32'h0);
    end
    enter_code(16'h1235);
    step();
    check_outs("t2.lock", 4'hF, 1'b0, 1'b0, 1'b1, 4'd3);
    run_timed(2, 40, n);
    check_eq("t2.lock_len", 32'(n), 32'd40);
    check_outs("t2.after_lock", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Overflowed entry and short entry both fail.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check_eq("t3.ovf_disp", 32'(disp_val), 32'h4);
    press(ENT);
    step();
    check_outs("t3.ovf_err", 4'hE, 1'b0, 1'b1, 1'b0, 4'd1);
    run_timed(1, 10, n);
    press(4'h1); press(4'h2); press(ENT);
    step();
    check_outs("t3.short_err", 4'hE, 1'b0, 1'b1, 1'b0, 4'd2);
    run_timed(1, 10, n);

    // CLEAR abandons entry; CLEAR while unlocked relocks at once.
    press(4'h1); press(4'h2); press(CLR);
    check_outs("t4.cleared", 4'h0, 1'b0, 1'b0, 1'b0, 4'd2);
    enter_code(16'h1234);
    step();
    check_outs("t4.open", 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    step(); step();
    press(CLR);
    check_outs("t4.relock", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

`ifdef COMBO_PROG_EN
    // Program a new code, verify it, then reset restores the default.
    enter_code(16'h1234);
    step();
    press(ENT);
    check_outs("t5.prog", 4'hB, 1'b1, 1'b0, 1'b0, 4'd0);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check_eq("t5.prog_disp", 32'(disp_val), 32'h6);
    press(ENT);
    check_outs("t5.written", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    enter_code(16'h1234);
    step();
    check_outs("t5.old_fails", 4'hE, 1'b0, 1'b1, 1'b0, 4'd1);
    run_timed(1, 10, n);
    enter_code(16'h9876);
    step();
    check_outs("t5.new_opens", 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    do_reset();
    enter_code(16'h1234);
    step();
    check_outs("t5.default_back", 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    press(CLR);
`endif

    // Reset during lockout, with a simultaneous key strobe.
    for (int a = 0; a < 2; a++) begin
      enter_code(16'h5555);
      step();
      run_timed(1, 10, n);
    end
    enter_code(16'h5555);
    step();
    check_outs("t6.lock", 4'hF, 1'b0, 1'b0, 1'b1, 4'd3);
    step(); step();
    key_strobe = 1'b1;
    key_code   = 4'h1;
    do_reset();
    check_outs("t6.reset_lock", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset mid-entry discards the partial code.
    press(4'h1); press(4'h2);
    key_strobe = 1'b1;
    key_code   = 4'h3;
    do_reset();
    check_outs("t6.reset_entry", 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    enter_code(16'h1234);
    step();
    check_outs("t6.fresh_open", 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
